// File: rtl/mash_pkg.sv
// -----------------------------------------------------------------------------
// mash_pkg
// Shared constants and helpers for the MASH delta-sigma modulator.
//   LFSR_W / LFSR_TAPS / LFSR_SEED : dither LFSR geometry (x^15 + x^14 + 1)
//   out_width(order)               : minimum signed output width for an order
//   binom_coef(n, j)               : (-1)^j * C(n, j), the tap weights of
//                                    (1 - z^-1)^n, used by reference models
// -----------------------------------------------------------------------------
package mash_pkg;

   localparam int LFSR_W = 15;

   // Feedback from register bits 14 and 13 realises x^15 + x^14 + 1.
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 15'h6000;
   localparam logic [LFSR_W-1:0] LFSR_SEED = 15'h0001;

   function automatic int out_width(input int order);
      return order + 1;
   endfunction

   function automatic int binom_coef(input int n, input int j);
      int c;
      c = 1;
      for (int t = 0; t < j; t++) begin
         c = c * (n - t) / (t + 1);
      end
      return (j % 2 == 1) ? -c : c;
   endfunction

endpackage

// File: rtl/mash_acc_stage.sv
// -----------------------------------------------------------------------------
// mash_acc_stage
// One first-order accumulator stage of the MASH cascade.
//   clk, rst     : clock, asynchronous active-high reset
//   i_en         : commit the new residue this cycle
//   i_addend     : value added to the accumulator (frac word or previous residue)
//   i_carry_in   : extra LSB carry (dither, first stage only)
//   o_residue    : new residue, available combinationally in the same cycle
//   o_carry      : quantiser output (overflow of the sum)
// -----------------------------------------------------------------------------
module mash_acc_stage #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_addend,
   input  logic             i_carry_in,
   output logic [WIDTH-1:0] o_residue,
   output logic             o_carry
);

   logic [WIDTH-1:0] r_acc;
   logic [WIDTH:0]   w_sum;

   // One extra bit holds the overflow; the accumulator itself wraps mod 2^WIDTH.
   assign w_sum     = {1'b0, r_acc} + {1'b0, i_addend} + {{WIDTH{1'b0}}, i_carry_in};
   assign o_residue = w_sum[WIDTH-1:0];
   assign o_carry   = w_sum[WIDTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc <= '0;
      end else if (i_en) begin
         r_acc <= w_sum[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/mash_nth_modulator.sv
// -----------------------------------------------------------------------------
// mash_nth_modulator
// MASH delta-sigma modulator of order 1..4: cascaded accumulators plus a
// digital noise-cancellation network. Long-run mean of y_out = frac/2^WIDTH.
//   clk       : clock
//   rst       : asynchronous active-high reset
//   en        : advance the modulator one step this cycle
//   frac_in   : unsigned fractional word
//   frac_load : capture frac_in into the fractional register
//   dither_en : add LFSR bit as carry-in to stage 1
//   y_out     : signed modulator output (registered)
//   y_valid   : one-cycle pulse after every step
// -----------------------------------------------------------------------------
module mash_nth_modulator
   import mash_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int ORDER = 3,
   parameter int OUT_W = out_width(ORDER)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [WIDTH-1:0]        frac_in,
   input  logic                    frac_load,
   input  logic                    dither_en,
   output logic signed [OUT_W-1:0] y_out,
   output logic                    y_valid
);

   logic [WIDTH-1:0]        r_frac;
   logic [LFSR_W-1:0]       r_lfsr;
   logic                    w_dither;
   logic [ORDER-1:0]        w_carry;
   logic signed [OUT_W-1:0] w_d     [ORDER];
   logic signed [OUT_W-1:0] r_dhist [ORDER];
   logic signed [OUT_W-1:0] r_y;
   logic                    r_valid;
   logic [WIDTH-1:0]        w_unused_tail;
   logic signed [OUT_W-1:0] w_unused_hist;

   // The fractional register is loaded independently of stepping, so a step
   // in the load cycle still sees the previous word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_frac <= '0;
      end else if (frac_load) begin
         r_frac <= frac_in;
      end
   end

   assign w_dither = dither_en & r_lfsr[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lfsr <= LFSR_SEED;
      end else if (en && dither_en) begin
         r_lfsr <= {r_lfsr[LFSR_W-2:0], ^(r_lfsr & LFSR_TAPS)};
      end
   end

   // Accumulator cascade: each stage adds the previous stage's new residue
   // within the same cycle.
   generate
      for (genvar gi = 0; gi < ORDER; gi++) begin : g_stage
         logic [WIDTH-1:0] w_addend;
         logic [WIDTH-1:0] w_residue;
         logic             w_cin;

         if (gi == 0) begin : g_first
            assign w_addend = r_frac;
            assign w_cin    = w_dither;
         end else begin : g_next
            assign w_addend = g_stage[gi-1].w_residue;
            assign w_cin    = 1'b0;
         end

         mash_acc_stage #(
            .WIDTH(WIDTH)
         ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .i_en      (en),
            .i_addend  (w_addend),
            .i_carry_in(w_cin),
            .o_residue (w_residue),
            .o_carry   (w_carry[gi])
         );
      end
   endgenerate

   // The last stage's residue and the level-1 history have no consumer.
   assign w_unused_tail = g_stage[ORDER-1].w_residue;
   assign w_unused_hist = r_dhist[0];

   // Cancellation network, evaluated from the deepest level upwards:
   //   D_ORDER = c_ORDER
   //   D_k     = c_k + D_(k+1)[n] - D_(k+1)[n-1]
   always_comb begin
      for (int i = 0; i < ORDER; i++) begin
         w_d[i] = '0;
      end
      w_d[ORDER-1] = $signed({{(OUT_W-1){1'b0}}, w_carry[ORDER-1]});
      for (int i = ORDER - 2; i >= 0; i--) begin
         w_d[i] = $signed({{(OUT_W-1){1'b0}}, w_carry[i]}) + w_d[i+1] - r_dhist[i+1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_y     <= '0;
         r_valid <= 1'b0;
         for (int i = 0; i < ORDER; i++) begin
            r_dhist[i] <= '0;
         end
      end else begin
         r_valid <= en;
         if (en) begin
            r_y <= w_d[0];
            for (int i = 0; i < ORDER; i++) begin
               r_dhist[i] <= w_d[i];
            end
         end
      end
   end

   assign y_out   = r_y;
   assign y_valid = r_valid;

endmodule
